// File: rtl/multicycle_control_if.sv
// Handshake/strobe bundle between the multi-cycle control FSM and the datapath.
// master = control FSM, slave = datapath / memory side.
interface multicycle_control_if #(
  parameter int OPW    = 6,
  parameter int ALUOPW = 2
);
  logic [OPW-1:0]    opcode;
  logic              mem_ready;
  logic              PCWrite;
  logic              PCWriteCond;
  logic              IorD;
  logic              memRead;
  logic              memWrite;
  logic              IRWrite;
  logic              memToReg;
  logic              RegDest;
  logic              RegWrite;
  logic              ALUSrcA;
  logic [1:0]        ALUSrcB;
  logic [ALUOPW-1:0] ALUOp;
  logic [1:0]        PCSource;
  logic              instr_done;
  logic [1:0]        fault;
  logic [3:0]        state;

  modport master (
    input  opcode, mem_ready,
    output PCWrite, PCWriteCond, IorD, memRead, memWrite,
    output IRWrite, memToReg, RegDest, RegWrite, ALUSrcA,
    output ALUSrcB, ALUOp, PCSource, instr_done, fault, state
  );

  modport slave (
    output opcode, mem_ready,
    input  PCWrite, PCWriteCond, IorD, memRead, memWrite,
    input  IRWrite, memToReg, RegDest, RegWrite, ALUSrcA,
    input  ALUSrcB, ALUOp, PCSource, instr_done, fault, state
  );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS main control FSM with memory handshake and illegal-opcode trap.
// Optional memory-wait timeout enabled by defining MCTRL_MEM_TIMEOUT_EN.
module multicycle_control #(
  parameter int OPW         = 6,
  parameter int ALUOPW      = 2,
  parameter int MEM_TIMEOUT = 16,
  parameter int TOW         = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  multicycle_control_if.master bus
);

  typedef enum logic [3:0] {
    S_RST    = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_BRANCH = 4'd11,
    S_JUMP   = 4'd12,
    S_TRAP   = 4'd15
  } state_t;

  localparam logic [OPW-1:0] OP_R    = OPW'(6'b000000);
  localparam logic [OPW-1:0] OP_LW   = OPW'(6'b001000);
  localparam logic [OPW-1:0] OP_SW   = OPW'(6'b010000);
  localparam logic [OPW-1:0] OP_ADDI = OPW'(6'b000010);
  localparam logic [OPW-1:0] OP_BEQ  = OPW'(6'b000100);
  localparam logic [OPW-1:0] OP_J    = OPW'(6'b100000);

  state_t r_state;
  state_t w_next;

  logic              w_is_r, w_is_lw, w_is_sw;
  logic              w_is_addi, w_is_beq, w_is_j;
  logic              w_ill;
  logic              w_to;
  logic              r_fault_ill;

  logic              w_PCWrite, w_PCWriteCond, w_IorD;
  logic              w_memRead, w_memWrite, w_IRWrite;
  logic              w_memToReg, w_RegDest, w_RegWrite;
  logic              w_ALUSrcA, w_instr_done;
  logic [1:0]        w_ALUSrcB, w_PCSource;
  logic [ALUOPW-1:0] w_ALUOp;

  assign w_is_r    = (bus.opcode == OP_R);
  assign w_is_lw   = (bus.opcode == OP_LW);
  assign w_is_sw   = (bus.opcode == OP_SW);
  assign w_is_addi = (bus.opcode == OP_ADDI);
  assign w_is_beq  = (bus.opcode == OP_BEQ);
  assign w_is_j    = (bus.opcode == OP_J);

  // State register; reset aborts any instruction in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_RST;
    else       r_state <= w_next;
  end

  // Next-state and Moore strobes (FETCH also has the IR/PC load Mealy terms)
  always_comb begin
    w_next        = r_state;
    w_ill         = 1'b0;
    w_PCWrite     = 1'b0;
    w_PCWriteCond = 1'b0;
    w_IorD        = 1'b0;
    w_memRead     = 1'b0;
    w_memWrite    = 1'b0;
    w_IRWrite     = 1'b0;
    w_memToReg    = 1'b0;
    w_RegDest     = 1'b0;
    w_RegWrite    = 1'b0;
    w_ALUSrcA     = 1'b0;
    w_ALUSrcB     = 2'b00;
    w_ALUOp       = '0;
    w_PCSource    = 2'b00;
    w_instr_done  = 1'b0;
    unique case (r_state)
      S_RST: w_next = S_FETCH;
      S_FETCH: begin
        w_memRead = 1'b1;
        w_ALUSrcB = 2'b01;
        w_IRWrite = bus.mem_ready;
        w_PCWrite = bus.mem_ready;
        if (bus.mem_ready) w_next = S_DECODE;
        else if (w_to)     w_next = S_TRAP;
      end
      S_DECODE: begin
        w_ALUSrcB = 2'b11;
        unique case (1'b1)
          w_is_lw, w_is_sw: w_next = S_MEMADR;
          w_is_r:           w_next = S_EXEC;
          w_is_addi:        w_next = S_ADDIEX;
          w_is_beq:         w_next = S_BRANCH;
          w_is_j:           w_next = S_JUMP;
          default: begin
            w_next = S_TRAP;
            w_ill  = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        w_ALUSrcA = 1'b1;
        w_ALUSrcB = 2'b10;
        w_next    = w_is_lw ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        w_memRead = 1'b1;
        w_IorD    = 1'b1;
        if (bus.mem_ready) w_next = S_MEMWB;
        else if (w_to)     w_next = S_TRAP;
      end
      S_MEMWB: begin
        w_RegWrite   = 1'b1;
        w_memToReg   = 1'b1;
        w_instr_done = 1'b1;
        w_next       = S_FETCH;
      end
      S_MEMWR: begin
        w_memWrite   = 1'b1;
        w_IorD       = 1'b1;
        w_instr_done = bus.mem_ready;
        if (bus.mem_ready) w_next = S_FETCH;
        else if (w_to)     w_next = S_TRAP;
      end
      S_EXEC: begin
        w_ALUSrcA = 1'b1;
        w_ALUOp   = ALUOPW'(2'b10);
        w_next    = S_ALUWB;
      end
      S_ALUWB: begin
        w_RegDest    = 1'b1;
        w_RegWrite   = 1'b1;
        w_instr_done = 1'b1;
        w_next       = S_FETCH;
      end
      S_ADDIEX: begin
        w_ALUSrcA = 1'b1;
        w_ALUSrcB = 2'b10;
        w_ALUOp   = ALUOPW'(2'b11);
        w_next    = S_ADDIWB;
      end
      S_ADDIWB: begin
        w_RegWrite   = 1'b1;
        w_instr_done = 1'b1;
        w_next       = S_FETCH;
      end
      S_BRANCH: begin
        w_ALUSrcA     = 1'b1;
        w_ALUOp       = ALUOPW'(2'b01);
        w_PCWriteCond = 1'b1;
        w_PCSource    = 2'b01;
        w_instr_done  = 1'b1;
        w_next        = S_FETCH;
      end
      S_JUMP: begin
        w_PCWrite    = 1'b1;
        w_PCSource   = 2'b10;
        w_instr_done = 1'b1;
        w_next       = S_FETCH;
      end
      S_TRAP: w_next = S_TRAP;
      default: w_next = S_RST;
    endcase
  end

  // Sticky illegal-opcode flag, cleared only by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      r_fault_ill <= 1'b0;
    else if (w_ill) r_fault_ill <= 1'b1;
  end

`ifdef MCTRL_MEM_TIMEOUT_EN
  logic [TOW-1:0] r_cnt;
  logic           w_wait;
  logic           r_fault_to;

  if (2**TOW <= MEM_TIMEOUT) begin : g_tow_chk
    $error("TOW too narrow for MEM_TIMEOUT");
  end

  assign w_wait = ((r_state == S_FETCH) ||
                   (r_state == S_MEMRD) ||
                   (r_state == S_MEMWR)) && !bus.mem_ready;
  assign w_to   = w_wait && (r_cnt == TOW'(MEM_TIMEOUT - 1));

  // Wait counter: cleared on any state change, so every wait state starts at 0
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  r_cnt <= '0;
    else if (w_next != r_state) r_cnt <= '0;
    else if (w_wait)            r_cnt <= r_cnt + 1'b1;
  end

  // Sticky memory-timeout flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     r_fault_to <= 1'b0;
    else if (w_to) r_fault_to <= 1'b1;
  end

  assign bus.fault = {r_fault_to, r_fault_ill};
`else
  assign w_to      = 1'b0;
  assign bus.fault = {1'b0, r_fault_ill};
`endif

  assign bus.PCWrite     = w_PCWrite;
  assign bus.PCWriteCond = w_PCWriteCond;
  assign bus.IorD        = w_IorD;
  assign bus.memRead     = w_memRead;
  assign bus.memWrite    = w_memWrite;
  assign bus.IRWrite     = w_IRWrite;
  assign bus.memToReg    = w_memToReg;
  assign bus.RegDest     = w_RegDest;
  assign bus.RegWrite    = w_RegWrite;
  assign bus.ALUSrcA     = w_ALUSrcA;
  assign bus.ALUSrcB     = w_ALUSrcB;
  assign bus.ALUOp       = w_ALUOp;
  assign bus.PCSource    = w_PCSource;
  assign bus.instr_done  = w_instr_done;
  assign bus.state       = r_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control.
// Tables hold hand-computed state and strobe vectors per cycle.
module tb_multicycle_control;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  multicycle_control_if #(.OPW(6), .ALUOPW(2)) bus ();

  multicycle_control dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // bit order: PCWrite PCWriteCond IorD memRead memWrite IRWrite
  //   memToReg RegDest RegWrite ALUSrcA ALUSrcB[2] ALUOp[2] PCSource[2] done
  localparam logic [16:0] O_ZERO = 17'b0_0_0_0_0_0_0_0_0_0_00_00_00_0;
  localparam logic [16:0] O_FR1  = 17'b1_0_0_1_0_1_0_0_0_0_01_00_00_0;
  localparam logic [16:0] O_FR0  = 17'b0_0_0_1_0_0_0_0_0_0_01_00_00_0;
  localparam logic [16:0] O_DEC  = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_0;
  localparam logic [16:0] O_MADR = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
  localparam logic [16:0] O_MRD  = 17'b0_0_1_1_0_0_0_0_0_0_00_00_00_0;
  localparam logic [16:0] O_MWB  = 17'b0_0_0_0_0_0_1_0_1_0_00_00_00_1;
  localparam logic [16:0] O_MWR0 = 17'b0_0_1_0_1_0_0_0_0_0_00_00_00_0;
  localparam logic [16:0] O_MWR1 = 17'b0_0_1_0_1_0_0_0_0_0_00_00_00_1;
  localparam logic [16:0] O_EXEC = 17'b0_0_0_0_0_0_0_0_0_1_00_10_00_0;
  localparam logic [16:0] O_AWB  = 17'b0_0_0_0_0_0_0_1_1_0_00_00_00_1;
  localparam logic [16:0] O_AIEX = 17'b0_0_0_0_0_0_0_0_0_1_10_11_00_0;
  localparam logic [16:0] O_AIWB = 17'b0_0_0_0_0_0_0_0_1_0_00_00_00_1;
  localparam logic [16:0] O_BR   = 17'b0_1_0_0_0_0_0_0_0_1_00_01_01_1;
  localparam logic [16:0] O_JMP  = 17'b1_0_0_0_0_0_0_0_0_0_00_00_10_1;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b001000;
  localparam logic [5:0] OP_SW   = 6'b010000;
  localparam logic [5:0] OP_ADDI = 6'b000010;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b100000;
  localparam logic [5:0] OP_BAD  = 6'b111111;

  typedef struct {
    logic [5:0]  op;
    logic        rdy;
    logic [3:0]  st;
    logic [16:0] o;
  } step_t;

  function automatic logic [16:0] outs();
    return {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.memRead,
            bus.memWrite, bus.IRWrite, bus.memToReg, bus.RegDest,
            bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp,
            bus.PCSource, bus.instr_done};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.opcode = OP_R;
    bus.mem_ready = 1'b1;
    tick();
    tick();
    checks++;
    if (bus.state !== 4'd0) begin
      errors++;
      $display("FAIL reset_state: got %0d want 0", bus.state);
    end
    checks++;
    if (outs() !== O_ZERO) begin
      errors++;
      $display("FAIL reset_outs: got %b want %b", outs(), O_ZERO);
    end
    checks++;
    if (bus.fault !== 2'b00) begin
      errors++;
      $display("FAIL reset_fault: got %b want 00", bus.fault);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (bus.state !== 4'd1 || outs() !== O_FR1) begin
      errors++;
      $display("FAIL reset_release: got st=%0d o=%b want st=1 o=%b",
               bus.state, outs(), O_FR1);
    end
  endtask

  task automatic test_lw();
    step_t s[6];
    s = '{'{OP_LW, 1'b1, 4'd1, O_FR1},
          '{OP_LW, 1'b1, 4'd2, O_DEC},
          '{OP_LW, 1'b1, 4'd3, O_MADR},
          '{OP_LW, 1'b1, 4'd4, O_MRD},
          '{OP_LW, 1'b1, 4'd5, O_MWB},
          '{OP_LW, 1'b1, 4'd1, O_FR1}};
    for (int i = 0; i < 6; i++) begin
      bus.opcode = s[i].op;
      bus.mem_ready = s[i].rdy;
      #1;
      checks++;
      if (bus.state !== s[i].st || outs() !== s[i].o) begin
        errors++;
        $display("FAIL lw step %0d: got st=%0d o=%b want st=%0d o=%b",
                 i, bus.state, outs(), s[i].st, s[i].o);
      end
      if (i < 5) tick();
    end
  endtask

  task automatic test_rtype_addi();
    step_t s[9];
    s = '{'{OP_R,    1'b1, 4'd1,  O_FR1},
          '{OP_R,    1'b1, 4'd2,  O_DEC},
          '{OP_R,    1'b1, 4'd7,  O_EXEC},
          '{OP_R,    1'b1, 4'd8,  O_AWB},
          '{OP_ADDI, 1'b1, 4'd1,  O_FR1},
          '{OP_ADDI, 1'b1, 4'd2,  O_DEC},
          '{OP_ADDI, 1'b1, 4'd9,  O_AIEX},
          '{OP_ADDI, 1'b1, 4'd10, O_AIWB},
          '{OP_ADDI, 1'b1, 4'd1,  O_FR1}};
    for (int i = 0; i < 9; i++) begin
      bus.opcode = s[i].op;
      bus.mem_ready = s[i].rdy;
      #1;
      checks++;
      if (bus.state !== s[i].st || outs() !== s[i].o) begin
        errors++;
        $display("FAIL r_addi step %0d: got st=%0d o=%b want st=%0d o=%b",
                 i, bus.state, outs(), s[i].st, s[i].o);
      end
      if (i < 8) tick();
    end
  endtask

  task automatic test_beq_j();
    step_t s[7];
    s = '{'{OP_BEQ, 1'b1, 4'd1,  O_FR1},
          '{OP_BEQ, 1'b0, 4'd2,  O_DEC},
          '{OP_BEQ, 1'b0, 4'd11, O_BR},
          '{OP_J,   1'b1, 4'd1,  O_FR1},
          '{OP_J,   1'b0, 4'd2,  O_DEC},
          '{OP_J,   1'b0, 4'd12, O_JMP},
          '{OP_J,   1'b1, 4'd1,  O_FR1}};
    for (int i = 0; i < 7; i++) begin
      bus.opcode = s[i].op;
      bus.mem_ready = s[i].rdy;
      #1;
      checks++;
      if (bus.state !== s[i].st || outs() !== s[i].o) begin
        errors++;
        $display("FAIL beq_j step %0d: got st=%0d o=%b want st=%0d o=%b",
                 i, bus.state, outs(), s[i].st, s[i].o);
      end
      if (i < 6) tick();
    end
  endtask

  task automatic test_sw_wait();
    step_t s[11];
    s = '{'{OP_SW, 1'b0, 4'd1, O_FR0},
          '{OP_SW, 1'b0, 4'd1, O_FR0},
          '{OP_SW, 1'b1, 4'd1, O_FR1},
          '{OP_SW, 1'b0, 4'd2, O_DEC},
          '{OP_SW, 1'b0, 4'd3, O_MADR},
          '{OP_SW, 1'b0, 4'd6, O_MWR0},
          '{OP_SW, 1'b0, 4'd6, O_MWR0},
          '{OP_SW, 1'b0, 4'd6, O_MWR0},
          '{OP_SW, 1'b1, 4'd6, O_MWR1},
          '{OP_SW, 1'b0, 4'd1, O_FR0},
          '{OP_SW, 1'b1, 4'd1, O_FR1}};
    for (int i = 0; i < 11; i++) begin
      bus.opcode = s[i].op;
      bus.mem_ready = s[i].rdy;
      #1;
      checks++;
      if (bus.state !== s[i].st || outs() !== s[i].o) begin
        errors++;
        $display("FAIL sw_wait step %0d: got st=%0d o=%b want st=%0d o=%b",
                 i, bus.state, outs(), s[i].st, s[i].o);
      end
      if (i < 10) tick();
    end
  endtask

  task automatic test_reset_midinstr();
    step_t s[5];
    s = '{'{OP_LW, 1'b1, 4'd1, O_FR1},
          '{OP_LW, 1'b1, 4'd2, O_DEC},
          '{OP_LW, 1'b1, 4'd3, O_MADR},
          '{OP_LW, 1'b0, 4'd4, O_MRD},
          '{OP_LW, 1'b0, 4'd4, O_MRD}};
    for (int i = 0; i < 5; i++) begin
      bus.opcode = s[i].op;
      bus.mem_ready = s[i].rdy;
      #1;
      checks++;
      if (bus.state !== s[i].st || outs() !== s[i].o) begin
        errors++;
        $display("FAIL rst_mid step %0d: got st=%0d o=%b want st=%0d o=%b",
                 i, bus.state, outs(), s[i].st, s[i].o);
      end
      if (i < 4) tick();
    end
    reset = 1'b1;
    #1;
    checks++;
    if (bus.state !== 4'd0 || outs() !== O_ZERO || bus.fault !== 2'b00) begin
      errors++;
      $display("FAIL rst_mid_abort: got st=%0d o=%b f=%b want st=0 o=0 f=00",
               bus.state, outs(), bus.fault);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (bus.state !== 4'd1 || outs() !== O_FR0) begin
      errors++;
      $display("FAIL rst_mid_fetch: got st=%0d o=%b want st=1 o=%b",
               bus.state, outs(), O_FR0);
    end
    bus.mem_ready = 1'b1;
    #1;
  endtask

  task automatic test_trap();
    bus.opcode = OP_BAD;
    bus.mem_ready = 1'b1;
    tick();
    checks++;
    if (bus.state !== 4'd2 || bus.fault !== 2'b00) begin
      errors++;
      $display("FAIL trap_decode: got st=%0d f=%b want st=2 f=00",
               bus.state, bus.fault);
    end
    tick();
    for (int i = 0; i < 20; i++) begin
      bus.mem_ready = i[0];
      bus.opcode = (i[1]) ? OP_LW : OP_BAD;
      #1;
      checks++;
      if (bus.state !== 4'd15 || bus.fault !== 2'b01 || outs() !== O_ZERO) begin
        errors++;
        $display("FAIL trap_hold cyc %0d: got st=%0d f=%b o=%b want st=15 f=01 o=0",
                 i, bus.state, bus.fault, outs());
      end
      tick();
    end
  endtask

  task automatic test_timeout();
    reset = 1'b1;
    bus.opcode = OP_LW;
    bus.mem_ready = 1'b0;
    tick();
    reset = 1'b0;
    tick();
`ifdef MCTRL_MEM_TIMEOUT_EN
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (bus.state !== 4'd1 || bus.fault !== 2'b00) begin
        errors++;
        $display("FAIL to_wait cyc %0d: got st=%0d f=%b want st=1 f=00",
                 i, bus.state, bus.fault);
      end
      tick();
    end
    checks++;
    if (bus.state !== 4'd15 || bus.fault !== 2'b10 || outs() !== O_ZERO) begin
      errors++;
      $display("FAIL to_trap: got st=%0d f=%b o=%b want st=15 f=10 o=0",
               bus.state, bus.fault, outs());
    end
`else
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (bus.state !== 4'd1 || bus.fault !== 2'b00 || outs() !== O_FR0) begin
        errors++;
        $display("FAIL no_to_wait cyc %0d: got st=%0d f=%b o=%b want st=1 f=00",
                 i, bus.state, bus.fault, outs());
      end
      tick();
    end
`endif
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset = 1'b1;
    bus.opcode = OP_R;
    bus.mem_ready = 1'b0;
    test_reset();
    test_lw();
    test_rtype_addi();
    test_beq_j();
    test_sw_wait();
    test_reset_midinstr();
    test_trap();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
